// File: rtl/parser_pkg.sv
// parser_pkg: shared widths, header word array type and extractor state encoding
package parser_pkg;
    localparam int DATA_W    = 32;
    localparam int HDR_BEATS = 4;

    typedef logic [HDR_BEATS-1:0][DATA_W-1:0] hdr_t;

    typedef enum logic {HDR, PAYLOAD} ext_state_t;
endpackage

// File: rtl/header_extractor_if.sv
// header_extractor_if: AXI-Stream data/valid/ready/last bundle
interface header_extractor_if;
    import parser_pkg::*;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/header_extractor_hdr_out_reg.sv
// hdr_out_reg: holds one complete header until the downstream consumer takes it
module hdr_out_reg
    import parser_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  hdr_t data_i,
    input  logic ready_i,
    output hdr_t data_o,
    output logic valid_o
);
    hdr_t data_q;
    logic valid_q;

    assign data_o  = data_q;
    assign valid_o = valid_q;

    // A load wins over a take, so a header completing as the old one leaves keeps valid high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/header_extractor.sv
// header_extractor: captures the header beats of each packet and passes the payload through
module header_extractor
    import parser_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    header_extractor_if.slave     s,
    header_extractor_if.master    m,
    input  logic [HDR_BEATS-1:0]  stage_ready,
    output hdr_t                  hdr_data,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic                  err_short,
    output logic                  err_stage
);
    ext_state_t           state_q, state_d;
    logic [HDR_BEATS-1:0] mask_q, mask_d;
    hdr_t                 cap_q, cap_d;
    logic                 err_short_q, err_short_d;
    logic                 err_stage_q, err_stage_d;
    logic                 load, s_ready, acc;

    // Header beats stall only while a finished header is held and not being taken
    assign s_ready   = (state_q == PAYLOAD) ? m.tready : !(hdr_valid && !hdr_ready);
    assign acc       = s.tvalid && s_ready;
    assign s.tready  = s_ready;
    assign m.tvalid  = (state_q == PAYLOAD) && s.tvalid;
    assign m.tdata   = s.tdata;
    assign m.tlast   = s.tlast;
    assign err_short = err_short_q;
    assign err_stage = err_stage_q;

    // Next state: store one-hot header words, close the header on the last stage or on tlast
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cap_d       = cap_q;
        err_short_d = 1'b0;
        err_stage_d = 1'b0;
        load        = 1'b0;
        if (acc && state_q == PAYLOAD) begin
            if (s.tlast) state_d = HDR;
        end else if (acc) begin
            if ($onehot(stage_ready)) begin
                mask_d = mask_q | stage_ready;
                for (int i = 0; i < HDR_BEATS; i++)
                    if (stage_ready[i]) cap_d[i] = s.tdata;
            end else begin
                err_stage_d = 1'b1;
            end
            if (stage_ready[HDR_BEATS-1]) begin
                load        = &mask_d;
                err_short_d = !(&mask_d);
                mask_d      = '0;
                if (!s.tlast) state_d = PAYLOAD;
            end else if (s.tlast) begin
                err_short_d = 1'b1;
                mask_d      = '0;
            end
        end
    end

    // State, partial-header buffer and error pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HDR;
            mask_q      <= '0;
            cap_q       <= '0;
            err_short_q <= 1'b0;
            err_stage_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cap_q       <= cap_d;
            err_short_q <= err_short_d;
            err_stage_q <= err_stage_d;
        end
    end

    hdr_out_reg u_hdr_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (cap_d),
        .ready_i (hdr_ready),
        .data_o  (hdr_data),
        .valid_o (hdr_valid)
    );
endmodule

// File: tb/tb_header_extractor.sv
// tb_header_extractor: directed scenarios plus randomized packets against a packet-level model
module tb_header_extractor;
    import parser_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] stage_ready = '0;
    hdr_t       hdr_data;
    logic       hdr_valid;
    logic       hdr_ready = 1'b0;
    logic       err_short, err_stage;
    int         passed = 0, total = 0;
    bit         rnd_en = 0;

    hdr_t        obs_hdr[$], exp_hdr[$];
    logic [32:0] obs_pay[$], exp_pay[$];
    int          n_short = 0, n_stage = 0, exp_short = 0, exp_stage = 0;
    logic [31:0] pkt_d[$];
    logic [3:0]  pkt_st[$];

    header_extractor_if s_if ();
    header_extractor_if m_if ();

    header_extractor dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s_if),
        .m           (m_if),
        .stage_ready (stage_ready),
        .hdr_data    (hdr_data),
        .hdr_valid   (hdr_valid),
        .hdr_ready   (hdr_ready),
        .err_short   (err_short),
        .err_stage   (err_stage)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (hdr_valid && hdr_ready) obs_hdr.push_back(hdr_data);
                if (m_if.tvalid && m_if.tready) obs_pay.push_back({m_if.tlast, m_if.tdata});
                n_short += int'(err_short);
                n_stage += int'(err_stage);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_en) begin
                m_if.tready = 1'($urandom_range(0, 1));
                hdr_ready   = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_hdr.delete();
        obs_pay.delete();
        n_short = 0;
        n_stage = 0;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] st, input logic l);
        s_if.tdata  = d;
        stage_ready = st;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_if.tready) begin
                @(posedge clk);
                #1;
                s_if.tvalid = 1'b0;
                return;
            end
        end
        total++;
        $display("FAIL drive_timeout: s_tready=%b for beat %h, required 1 within 300 cycles", s_if.tready, d);
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt();
        hdr_t       h = '0;
        logic [3:0] got = '0;
        bit         in_hdr = 1;
        int         n = pkt_d.size();
        for (int i = 0; i < n; i++) begin
            bit last = (i == n - 1);
            if (!in_hdr) begin
                exp_pay.push_back({last, pkt_d[i]});
            end else begin
                if ($countones(pkt_st[i]) == 1) begin
                    for (int k = 0; k < 4; k++) if (pkt_st[i][k]) h[k] = pkt_d[i];
                    got |= pkt_st[i];
                end else begin
                    exp_stage++;
                end
                if (pkt_st[i][3]) begin
                    if (got == 4'hF) exp_hdr.push_back(h);
                    else exp_short++;
                    got = '0;
                    in_hdr = last;
                end else if (last) begin
                    exp_short++;
                    got = '0;
                end
            end
            drive(pkt_d[i], pkt_st[i], last);
        end
    endtask

    task automatic test_reset();
        total++; if (hdr_valid !== 1'b0) $display("FAIL reset_hdr_valid: got %b want 0", hdr_valid); else passed++;
        total++; if (hdr_data !== '0) $display("FAIL reset_hdr_data: got %h want 0", hdr_data); else passed++;
        total++; if (err_short !== 1'b0) $display("FAIL reset_err_short: got %b want 0", err_short); else passed++;
        total++; if (err_stage !== 1'b0) $display("FAIL reset_err_stage: got %b want 0", err_stage); else passed++;
        total++; if (s_if.tready !== 1'b1) $display("FAIL reset_s_tready: got %b want 1", s_if.tready); else passed++;
        total++; if (m_if.tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_if.tvalid); else passed++;
        @(posedge clk);
        #1 rst = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_basic();
        time t0;
        hdr_ready = 1'b1;
        m_if.tready = 1'b1;
        clear_obs();
        drive(32'hA0, 4'b0001, 1'b0);
        drive(32'hA1, 4'b0010, 1'b0);
        drive(32'hA2, 4'b0100, 1'b0);
        total++; if (hdr_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", hdr_valid); else passed++;
        drive(32'hA3, 4'b1000, 1'b0);
        t0 = $time;
        total++; if (hdr_valid !== 1'b1) $display("FAIL basic_hdr_valid: got %b want 1", hdr_valid); else passed++;
        total++; if (hdr_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) $display("FAIL basic_hdr_data: got %h want a3a2a1a0", hdr_data); else passed++;
        drive(32'hA4, 4'b0101, 1'b0);
        total++; if ($time - t0 != 10) $display("FAIL basic_payload_latency: got %0t want 10", $time - t0); else passed++;
        drive(32'hA5, 4'b0001, 1'b1);
        wait_cycles(3);
        total++; if (obs_hdr.size() != 1) $display("FAIL basic_hdr_count: got %0d want 1", obs_hdr.size()); else passed++;
        total++; if (obs_pay.size() != 2) $display("FAIL basic_pay_count: got %0d want 2", obs_pay.size()); else passed++;
        total++; if (obs_pay[0] !== {1'b0, 32'hA4}) $display("FAIL basic_pay0: got %h want 0_a4", obs_pay[0]); else passed++;
        total++; if (obs_pay[1] !== {1'b1, 32'hA5}) $display("FAIL basic_pay1: got %h want 1_a5", obs_pay[1]); else passed++;
    endtask

    task automatic test_backpressure();
        hdr_ready = 1'b0;
        m_if.tready = 1'b1;
        clear_obs();
        drive(32'h10, 4'b0001, 1'b0);
        drive(32'h11, 4'b0010, 1'b0);
        drive(32'h12, 4'b0100, 1'b0);
        drive(32'h13, 4'b1000, 1'b1);
        s_if.tdata = 32'h20;
        stage_ready = 4'b0001;
        s_if.tlast = 1'b0;
        s_if.tvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++; if (s_if.tready !== 1'b0) $display("FAIL bp_stall: got s_tready %b want 0", s_if.tready); else passed++;
            total++; if (hdr_data !== {32'h13, 32'h12, 32'h11, 32'h10}) $display("FAIL bp_hold: got %h want 13121110", hdr_data); else passed++;
        end
        @(posedge clk);
        #1 hdr_ready = 1'b1;
        @(negedge clk);
        total++; if (s_if.tready !== 1'b1) $display("FAIL bp_release: got s_tready %b want 1", s_if.tready); else passed++;
        @(posedge clk);
        #1 s_if.tvalid = 1'b0;
        drive(32'h21, 4'b0010, 1'b0);
        drive(32'h22, 4'b0100, 1'b0);
        drive(32'h23, 4'b1000, 1'b1);
        total++; if (hdr_data !== {32'h23, 32'h22, 32'h21, 32'h20}) $display("FAIL bp_second_hdr: got %h want 23222120", hdr_data); else passed++;
        wait_cycles(2);
        total++; if (obs_hdr.size() != 2) $display("FAIL bp_hdr_count: got %0d want 2", obs_hdr.size()); else passed++;
        total++; if (obs_hdr[0] !== {32'h13, 32'h12, 32'h11, 32'h10}) $display("FAIL bp_first_taken: got %h want 13121110", obs_hdr[0]); else passed++;
    endtask

    task automatic test_short();
        hdr_ready = 1'b1;
        m_if.tready = 1'b1;
        wait_cycles(2);
        clear_obs();
        drive(32'hB0, 4'b0001, 1'b0);
        drive(32'hB1, 4'b0010, 1'b0);
        drive(32'hB2, 4'b0100, 1'b1);
        total++; if (err_short !== 1'b1) $display("FAIL short_pulse: got %b want 1", err_short); else passed++;
        total++; if (hdr_valid !== 1'b0) $display("FAIL short_no_hdr: got %b want 0", hdr_valid); else passed++;
        wait_cycles(1);
        total++; if (err_short !== 1'b0) $display("FAIL short_pulse_end: got %b want 0", err_short); else passed++;
        drive(32'hC0, 4'b0001, 1'b0);
        drive(32'hC1, 4'b0010, 1'b0);
        drive(32'hC2, 4'b0100, 1'b0);
        drive(32'hC3, 4'b1000, 1'b0);
        drive(32'hC4, 4'b0000, 1'b1);
        wait_cycles(2);
        total++; if (n_short != 1) $display("FAIL short_count: got %0d want 1", n_short); else passed++;
        total++; if (obs_hdr.size() != 1 || obs_hdr[0] !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) $display("FAIL short_next_hdr: got %0d headers, first %h, want 1 of c3c2c1c0", obs_hdr.size(), obs_hdr[0]); else passed++;
        total++; if (obs_pay.size() != 1 || obs_pay[0] !== {1'b1, 32'hC4}) $display("FAIL short_next_pay: got %0d beats, first %h, want 1_c4", obs_pay.size(), obs_pay[0]); else passed++;
    endtask

    task automatic test_hdr_only();
        hdr_ready = 1'b1;
        m_if.tready = 1'b1;
        wait_cycles(2);
        clear_obs();
        drive(32'hD0, 4'b0001, 1'b0);
        drive(32'hD1, 4'b0010, 1'b0);
        drive(32'hD2, 4'b0100, 1'b0);
        drive(32'hD3, 4'b1000, 1'b1);
        total++; if (hdr_valid !== 1'b1) $display("FAIL hdronly_valid: got %b want 1", hdr_valid); else passed++;
        drive(32'hE0, 4'b0001, 1'b0);
        drive(32'hE1, 4'b0010, 1'b0);
        drive(32'hE2, 4'b0100, 1'b0);
        drive(32'hE3, 4'b1000, 1'b1);
        wait_cycles(2);
        total++; if (obs_pay.size() != 0) $display("FAIL hdronly_no_payload: got %0d beats want 0", obs_pay.size()); else passed++;
        total++; if (obs_hdr.size() != 2 || obs_hdr[1] !== {32'hE3, 32'hE2, 32'hE1, 32'hE0}) $display("FAIL hdronly_next_hdr: got %0d headers, second %h, want e3e2e1e0", obs_hdr.size(), obs_hdr[1]); else passed++;
    endtask

    task automatic test_bad_stage();
        hdr_ready = 1'b1;
        m_if.tready = 1'b1;
        wait_cycles(2);
        clear_obs();
        drive(32'hF0, 4'b0001, 1'b0);
        drive(32'hF1, 4'b0011, 1'b0);
        total++; if (err_stage !== 1'b1) $display("FAIL bad_stage_pulse: got %b want 1", err_stage); else passed++;
        drive(32'hF2, 4'b0100, 1'b0);
        drive(32'hF3, 4'b1000, 1'b0);
        total++; if (err_short !== 1'b1) $display("FAIL bad_stage_short: got %b want 1", err_short); else passed++;
        drive(32'hF4, 4'b0000, 1'b1);
        wait_cycles(2);
        total++; if (n_stage != 1) $display("FAIL bad_stage_count: got %0d want 1", n_stage); else passed++;
        total++; if (n_short != 1) $display("FAIL bad_stage_short_count: got %0d want 1", n_short); else passed++;
        total++; if (obs_hdr.size() != 0) $display("FAIL bad_stage_no_hdr: got %0d want 0", obs_hdr.size()); else passed++;
        total++; if (obs_pay.size() != 1 || obs_pay[0] !== {1'b1, 32'hF4}) $display("FAIL bad_stage_pay: got %0d beats, first %h, want 1_f4", obs_pay.size(), obs_pay[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        hdr_ready = 1'b0;
        m_if.tready = 1'b1;
        wait_cycles(2);
        drive(32'h60, 4'b0001, 1'b0);
        drive(32'h61, 4'b0010, 1'b0);
        drive(32'h62, 4'b0100, 1'b0);
        drive(32'h63, 4'b1000, 1'b0);
        drive(32'h64, 4'b0000, 1'b0);
        s_if.tdata = 32'h65;
        stage_ready = 4'b0001;
        s_if.tlast = 1'b0;
        s_if.tvalid = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++; if (m_if.tvalid !== 1'b0) $display("FAIL rstmid_m_tvalid: got %b want 0", m_if.tvalid); else passed++;
        total++; if (hdr_valid !== 1'b0) $display("FAIL rstmid_hdr_valid: got %b want 0", hdr_valid); else passed++;
        total++; if (hdr_data !== '0) $display("FAIL rstmid_hdr_data: got %h want 0", hdr_data); else passed++;
        total++; if (s_if.tready !== 1'b1) $display("FAIL rstmid_s_tready: got %b want 1", s_if.tready); else passed++;
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        hdr_ready = 1'b1;
        clear_obs();
        drive(32'h70, 4'b0001, 1'b0);
        drive(32'h71, 4'b0010, 1'b0);
        drive(32'h72, 4'b0100, 1'b0);
        drive(32'h73, 4'b1000, 1'b0);
        drive(32'h74, 4'b0000, 1'b1);
        wait_cycles(2);
        total++; if (obs_hdr.size() != 1 || obs_hdr[0] !== {32'h73, 32'h72, 32'h71, 32'h70}) $display("FAIL rstmid_next_hdr: got %0d headers, first %h, want 73727170", obs_hdr.size(), obs_hdr[0]); else passed++;
        total++; if (obs_pay.size() != 1 || obs_pay[0] !== {1'b1, 32'h74}) $display("FAIL rstmid_next_pay: got %0d beats, first %h, want 1_74", obs_pay.size(), obs_pay[0]); else passed++;
    endtask

    task automatic test_random();
        hdr_ready = 1'b1;
        m_if.tready = 1'b1;
        wait_cycles(2);
        clear_obs();
        exp_hdr.delete();
        exp_pay.delete();
        exp_short = 0;
        exp_stage = 0;
        rnd_en = 1;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 9);
            pkt_d.delete();
            pkt_st.delete();
            for (int k = 0; k < len; k++) begin
                pkt_d.push_back($urandom);
                if (k < 4 && $urandom_range(0, 9) < 8) pkt_st.push_back(4'(1 << k));
                else pkt_st.push_back(4'($urandom_range(0, 15)));
            end
            send_pkt();
        end
        rnd_en = 0;
        hdr_ready = 1'b1;
        m_if.tready = 1'b1;
        wait_cycles(20);
        total++; if (obs_hdr.size() != exp_hdr.size()) $display("FAIL rand_hdr_count: got %0d want %0d", obs_hdr.size(), exp_hdr.size()); else passed++;
        for (int i = 0; i < exp_hdr.size() && i < obs_hdr.size(); i++) begin
            total++; if (obs_hdr[i] !== exp_hdr[i]) $display("FAIL rand_hdr[%0d]: got %h want %h", i, obs_hdr[i], exp_hdr[i]); else passed++;
        end
        total++; if (obs_pay.size() != exp_pay.size()) $display("FAIL rand_pay_count: got %0d want %0d", obs_pay.size(), exp_pay.size()); else passed++;
        for (int i = 0; i < exp_pay.size() && i < obs_pay.size(); i++) begin
            total++; if (obs_pay[i] !== exp_pay[i]) $display("FAIL rand_pay[%0d]: got %h want %h", i, obs_pay[i], exp_pay[i]); else passed++;
        end
        total++; if (n_short != exp_short) $display("FAIL rand_err_short: got %0d want %0d", n_short, exp_short); else passed++;
        total++; if (n_stage != exp_stage) $display("FAIL rand_err_stage: got %0d want %0d", n_stage, exp_stage); else passed++;
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_hdr_only();
        test_bad_stage();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
